// File: rtl/algo_1r1w_scrub_ctrl.sv
// algo_1r1w_scrub_ctrl
//   Background ECC scrub sequencer placed in front of a single 1R1W
//   algorithmic memory. User traffic passes straight through with no added
//   latency. Scrub reads use only cycles without a user read. Write-backs of
//   corrected data use only cycles without a user write. Reads in flight are
//   tagged so that scrub returns never reach the user response port.
//
//   Optional build macro: SCRUB_DERR_STOP_EN
//     defined   : a scrub double-bit error parks the FSM in HALT until
//                 scrub_en is dropped
//     undefined : the double-bit error is logged and the pass continues
//
// Ports
//   clk, rst (async, active low), ready           clock / reset / memory ready
//   user_write/wr_adr/din, user_read/rd_adr       user requests
//   user_rd_vld/dout/serr/derr                    user read response
//   mem_write/wr_adr/din, mem_read/rd_adr         memory requests
//   mem_rd_vld/dout/serr/derr                     memory read response
//   scrub_en, scrub_intv                          scrub control
//   scrub_busy, pass_cnt, serr_cnt, derr_cnt,
//   derr_adr                                      scrub status
module algo_1r1w_scrub_ctrl #(
  parameter int WIDTH    = 32,
  parameter int NUMADDR  = 8192,
  parameter int BITADDR  = 13,
  parameter int RD_DELAY = 2,
  parameter int BITINTV  = 16,
  parameter int BITCNT   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ready,
  input  logic               user_write,
  input  logic [BITADDR-1:0] user_wr_adr,
  input  logic [WIDTH-1:0]   user_din,
  input  logic               user_read,
  input  logic [BITADDR-1:0] user_rd_adr,
  output logic               user_rd_vld,
  output logic [WIDTH-1:0]   user_rd_dout,
  output logic               user_rd_serr,
  output logic               user_rd_derr,
  output logic               mem_write,
  output logic [BITADDR-1:0] mem_wr_adr,
  output logic [WIDTH-1:0]   mem_din,
  output logic               mem_read,
  output logic [BITADDR-1:0] mem_rd_adr,
  input  logic               mem_rd_vld,
  input  logic [WIDTH-1:0]   mem_rd_dout,
  input  logic               mem_rd_serr,
  input  logic               mem_rd_derr,
  input  logic               scrub_en,
  input  logic [BITINTV-1:0] scrub_intv,
  output logic               scrub_busy,
  output logic [BITCNT-1:0]  pass_cnt,
  output logic [BITCNT-1:0]  serr_cnt,
  output logic [BITCNT-1:0]  derr_cnt,
  output logic [BITADDR-1:0] derr_adr
);

  typedef enum logic [2:0] {IDLE, WAIT, RD, RWAIT, WB, NEXT, HALT} state_t;

  state_t               state, nextState;
  logic [BITADDR-1:0]   scrubAdr;
  logic [BITINTV-1:0]   intvCnt;
  logic [WIDTH-1:0]     wbData;
  logic                 cancel;
  logic [RD_DELAY:1]    tagPipe;   // 1 = read issued in that slot was a scrub read
  logic [RD_DELAY:1]    vldPipe;   // 1 = a read was issued since reset in that slot
  logic                 scrubRd, scrubWr, scrubRsp, collide;

  function automatic logic [BITCNT-1:0] satInc(input logic [BITCNT-1:0] v);
    return (&v) ? v : v + BITCNT'(1);
  endfunction

  // Scrub issue only in free slots; user always wins.
  assign scrubRd  = (state == RD) & ready & ~user_read;
  assign scrubWr  = (state == WB) & ready & ~user_write & ~cancel;
  assign scrubRsp = mem_rd_vld & tagPipe[RD_DELAY];

  // A user write to the word being scrubbed, from the read issue onward,
  // makes the latched corrected data stale.
  assign collide = user_write & (user_wr_adr == scrubAdr) &
                   (scrubRd | (state == RWAIT) | (state == WB));

  assign mem_read   = user_read | scrubRd;
  assign mem_rd_adr = user_read ? user_rd_adr : scrubAdr;
  assign mem_write  = user_write | scrubWr;
  assign mem_wr_adr = user_write ? user_wr_adr : scrubAdr;
  assign mem_din    = user_write ? user_din : wbData;

  // vldPipe drops responses to reads issued before a reset, since the tag
  // pipe has lost their origin.
  assign user_rd_vld  = mem_rd_vld & vldPipe[RD_DELAY] & ~tagPipe[RD_DELAY];
  assign user_rd_dout = user_rd_vld ? mem_rd_dout : '0;
  assign user_rd_serr = user_rd_vld & mem_rd_serr;
  assign user_rd_derr = user_rd_vld & mem_rd_derr;

  assign scrub_busy = (state != IDLE);

  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (scrub_en && ready) nextState = WAIT;
      WAIT:  if (!scrub_en) nextState = IDLE;
             else if (intvCnt == '0) nextState = RD;
      RD:    if (scrubRd) nextState = RWAIT;
      RWAIT: if (scrubRsp) begin
`ifdef SCRUB_DERR_STOP_EN
               if (mem_rd_derr)      nextState = HALT;
`else
               if (mem_rd_derr)      nextState = NEXT;
`endif
               else if (mem_rd_serr) nextState = WB;
               else                  nextState = NEXT;
             end
      WB:    if (cancel || scrubWr) nextState = NEXT;
      NEXT:  nextState = scrub_en ? WAIT : IDLE;
`ifdef SCRUB_DERR_STOP_EN
      HALT:  if (!scrub_en) nextState = IDLE;
`endif
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      scrubAdr <= '0;
      intvCnt  <= '0;
      wbData   <= '0;
      cancel   <= 1'b0;
      tagPipe  <= '0;
      vldPipe  <= '0;
      pass_cnt <= '0;
      serr_cnt <= '0;
      derr_cnt <= '0;
      derr_adr <= '0;
    end else begin
      state <= nextState;

      tagPipe[1] <= scrubRd;
      vldPipe[1] <= mem_read;
      for (int i = 2; i <= RD_DELAY; i++) begin
        tagPipe[i] <= tagPipe[i-1];
        vldPipe[i] <= vldPipe[i-1];
      end

      if (nextState == WAIT && state != WAIT) intvCnt <= scrub_intv;
      else if (state == WAIT && intvCnt != '0) intvCnt <= intvCnt - BITINTV'(1);

      if (state == NEXT) cancel <= 1'b0;
      else if (collide)  cancel <= 1'b1;

      if (state == RWAIT && scrubRsp) begin
        if (mem_rd_derr) begin
          derr_cnt <= satInc(derr_cnt);
          derr_adr <= scrubAdr;
        end else if (mem_rd_serr) begin
          serr_cnt <= satInc(serr_cnt);
          wbData   <= mem_rd_dout;
        end
      end

      if (state == NEXT) begin
        if (scrubAdr == BITADDR'(NUMADDR - 1)) begin
          scrubAdr <= '0;
          pass_cnt <= satInc(pass_cnt);
        end else begin
          scrubAdr <= scrubAdr + BITADDR'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_algo_1r1w_scrub_ctrl.sv
// Directed bench for algo_1r1w_scrub_ctrl with a 16-word memory and a fixed
// two-cycle read model. Memory contents are 0xC0DE000<adr>; an injected
// single-bit error returns 0xA5A5A5A5.
module tb_algo_1r1w_scrub_ctrl;
  localparam int WIDTH = 32, NUMADDR = 16, BITADDR = 4, RD_DELAY = 2;
  localparam int BITINTV = 16, BITCNT = 16;

  logic               clk = 1'b0, rst = 1'b0, ready = 1'b1;
  logic               user_write = 1'b0, user_read = 1'b0;
  logic [BITADDR-1:0] user_wr_adr = '0, user_rd_adr = '0;
  logic [WIDTH-1:0]   user_din = '0;
  logic               user_rd_vld, user_rd_serr, user_rd_derr;
  logic [WIDTH-1:0]   user_rd_dout, mem_din, mem_rd_dout;
  logic               mem_write, mem_read, mem_rd_vld, mem_rd_serr, mem_rd_derr;
  logic [BITADDR-1:0] mem_wr_adr, mem_rd_adr, derr_adr;
  logic               scrub_en = 1'b0, scrub_busy;
  logic [BITINTV-1:0] scrub_intv = '0;
  logic [BITCNT-1:0]  pass_cnt, serr_cnt, derr_cnt;

  algo_1r1w_scrub_ctrl #(.WIDTH(WIDTH), .NUMADDR(NUMADDR), .BITADDR(BITADDR),
    .RD_DELAY(RD_DELAY), .BITINTV(BITINTV), .BITCNT(BITCNT)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .user_write(user_write), .user_wr_adr(user_wr_adr), .user_din(user_din),
    .user_read(user_read), .user_rd_adr(user_rd_adr),
    .user_rd_vld(user_rd_vld), .user_rd_dout(user_rd_dout),
    .user_rd_serr(user_rd_serr), .user_rd_derr(user_rd_derr),
    .mem_write(mem_write), .mem_wr_adr(mem_wr_adr), .mem_din(mem_din),
    .mem_read(mem_read), .mem_rd_adr(mem_rd_adr),
    .mem_rd_vld(mem_rd_vld), .mem_rd_dout(mem_rd_dout),
    .mem_rd_serr(mem_rd_serr), .mem_rd_derr(mem_rd_derr),
    .scrub_en(scrub_en), .scrub_intv(scrub_intv), .scrub_busy(scrub_busy),
    .pass_cnt(pass_cnt), .serr_cnt(serr_cnt), .derr_cnt(derr_cnt),
    .derr_adr(derr_adr));

  always #5 clk = ~clk;

  // Memory model: two-cycle read latency, not affected by the DUT reset.
  logic               p1v = 1'b0, p2v = 1'b0;
  logic [BITADDR-1:0] p1a = '0, p2a = '0;
  logic               injSerr = 1'b0, injDerr = 1'b0;
  logic [BITADDR-1:0] injSerrAdr = '0, injDerrAdr = '0;

  always @(posedge clk) begin
    p1v <= mem_read; p1a <= mem_rd_adr;
    p2v <= p1v;      p2a <= p1a;
  end
  assign mem_rd_vld  = p2v;
  assign mem_rd_serr = p2v & injSerr & (p2a == injSerrAdr);
  assign mem_rd_derr = p2v & injDerr & (p2a == injDerrAdr);
  assign mem_rd_dout = !p2v ? '0 : mem_rd_serr ? 32'hA5A5A5A5 : {28'hC0DE000, p2a};

  // Traffic monitor.
  int scrRdCnt = 0, wrCnt = 0, uVldCnt = 0;
  logic [BITADDR-1:0] lastScrAdr = '0, lastWrAdr = '0;
  logic [WIDTH-1:0]   lastWrDin = '0;
  always @(posedge clk) begin
    if (mem_read && !user_read) begin scrRdCnt++; lastScrAdr = mem_rd_adr; end
    if (mem_write) begin wrCnt++; lastWrAdr = mem_wr_adr; lastWrDin = mem_din; end
    if (user_rd_vld) uVldCnt++;
  end

  int nTests = 0, nFail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    rst = 1'b0; scrub_en = 1'b0; user_read = 1'b0; user_write = 1'b0;
    ready = 1'b1; injSerr = 1'b0; injDerr = 1'b0; scrub_intv = '0;
    tick(); tick();
    rst = 1'b1;
  endtask

  function automatic int probe(input int sel);
    case (sel)
      0: return scrRdCnt;
      1: return int'(serr_cnt);
      2: return int'(derr_cnt);
      default: return int'(pass_cnt);
    endcase
  endfunction

  // Advance until probe(sel) reaches target; a timeout is a failed check.
  task automatic waitUntil(input int sel, input int target, input string tag);
    int n = 0;
    while (probe(sel) < target && n < 400) begin tick(); n++; end
    chk({tag, "_timeout"}, 64'(probe(sel) >= target), 64'd1);
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (scrub_busy && n < 100) begin tick(); n++; end
    chk({tag, "_idle"}, 64'(scrub_busy), 64'd0);
  endtask

  int s0, w0, u0;

  initial begin
    // Reset state
    tick();
    chk("rst_busy", scrub_busy, 0);
    chk("rst_pass", pass_cnt, 0);
    chk("rst_serr", serr_cnt, 0);
    chk("rst_derr", derr_cnt, 0);
    chk("rst_dadr", derr_adr, 0);
    chk("rst_uvld", user_rd_vld, 0);
    chk("rst_mrd", mem_read, 0);
    chk("rst_mwr", mem_write, 0);

    // Full clean pass, back-to-back
    doReset();
    s0 = scrRdCnt; w0 = wrCnt; u0 = uVldCnt;
    scrub_en = 1'b1;
    waitUntil(3, 1, "pass");
    chk("pass_reads", scrRdCnt - s0, 16);
    chk("pass_last", lastScrAdr, 15);
    chk("pass_nowb", wrCnt - w0, 0);
    chk("pass_nouvld", uVldCnt - u0, 0);
    waitUntil(0, s0 + 17, "wrap");
    chk("wrap_adr0", lastScrAdr, 0);
    scrub_en = 1'b0;
    waitIdle("pass");

    // Single-bit error on addr 5 -> corrected write-back
    doReset();
    injSerr = 1'b1; injSerrAdr = 4'd5;
    w0 = wrCnt; u0 = uVldCnt;
    scrub_en = 1'b1;
    waitUntil(1, 1, "serr");
    chk("serr_mwr", mem_write, 1);
    chk("serr_wadr", mem_wr_adr, 5);
    chk("serr_din", mem_din, 32'hA5A5A5A5);
    scrub_en = 1'b0;
    tick(); tick();
    chk("serr_wrcnt", wrCnt - w0, 1);
    chk("serr_lastadr", lastWrAdr, 5);
    chk("serr_cnt", serr_cnt, 1);
    chk("serr_nouvld", uVldCnt - u0, 0);
    injSerr = 1'b0;
    waitIdle("serr");

    // User reads hold off the scrub read for 20 cycles
    doReset();
    u0 = uVldCnt;
    user_read = 1'b1; user_rd_adr = 4'd9; scrub_en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      chk("ur_adr", mem_rd_adr, 9);
      chk("ur_vld", user_rd_vld, 64'(c >= 2));
      chk("ur_dout", user_rd_dout, (c >= 2) ? 64'hC0DE0009 : 64'h0);
      tick();
    end
    user_read = 1'b0; #1;
    chk("ur_scrub_rd", mem_read, 1);
    chk("ur_scrub_adr", mem_rd_adr, 0);
    chk("ur_vld20", user_rd_vld, 1);
    tick();
    chk("ur_vld21", user_rd_vld, 1);
    chk("ur_rwait", mem_read, 0);
    tick();
    chk("ur_scrub_hidden", user_rd_vld, 0);
    chk("ur_scrub_dout", user_rd_dout, 0);
    chk("ur_vldcnt", uVldCnt - u0, 20);
    scrub_en = 1'b0;
    waitIdle("ur");

    // Write-back cancelled by a user write to the same address
    doReset();
    injSerr = 1'b1; injSerrAdr = 4'd7;
    scrub_en = 1'b1;
    waitUntil(1, 1, "coll");
    w0 = wrCnt; s0 = scrRdCnt;
    user_write = 1'b1; user_wr_adr = 4'd7; user_din = 32'h12345678; #1;
    chk("coll_mwr", mem_write, 1);
    chk("coll_wadr", mem_wr_adr, 7);
    chk("coll_din", mem_din, 32'h12345678);
    tick(); user_write = 1'b0; #1;
    chk("coll_cancel0", mem_write, 0);
    tick();
    chk("coll_cancel1", mem_write, 0);
    injSerr = 1'b0;
    waitUntil(0, s0 + 1, "coll_next");
    chk("coll_nextadr", lastScrAdr, 8);
    chk("coll_wrcnt", wrCnt - w0, 1);
    scrub_en = 1'b0;
    waitIdle("coll");

    // Double-bit error on addr 3
    doReset();
    injDerr = 1'b1; injDerrAdr = 4'd3;
    scrub_en = 1'b1;
    waitUntil(2, 1, "derr");
    chk("derr_cnt", derr_cnt, 1);
    chk("derr_adr", derr_adr, 3);
    chk("derr_noserr", serr_cnt, 0);
    injDerr = 1'b0;
    s0 = scrRdCnt;
`ifdef SCRUB_DERR_STOP_EN
    repeat (20) tick();
    chk("halt_noreads", scrRdCnt - s0, 0);
    chk("halt_busy", scrub_busy, 1);
    scrub_en = 1'b0;
    tick();
    chk("halt_exit", scrub_busy, 0);
    scrub_en = 1'b1;
`else
    waitUntil(0, s0 + 1, "derr_next");
    chk("derr_nextadr", lastScrAdr, 4);
`endif

    // Reset while a scrub read is in flight
    s0 = scrRdCnt; u0 = uVldCnt;
    waitUntil(0, s0 + 1, "rstfl");
    rst = 1'b0; #1;
    chk("rstfl_busy", scrub_busy, 0);
    chk("rstfl_derr", derr_cnt, 0);
    chk("rstfl_dadr", derr_adr, 0);
    chk("rstfl_pass", pass_cnt, 0);
    scrub_en = 1'b0; #1;
    rst = 1'b1;
    tick();
    chk("rstfl_late", user_rd_vld, 0);
    tick(); tick();
    chk("rstfl_uvldcnt", uVldCnt - u0, 0);

    // ready low: no scrub start, user write still passes
    doReset();
    ready = 1'b0; scrub_en = 1'b1;
    repeat (5) tick();
    chk("rdy_busy", scrub_busy, 0);
    chk("rdy_mrd", mem_read, 0);
    user_write = 1'b1; user_wr_adr = 4'd2; user_din = 32'hDEADBEEF; #1;
    chk("rdy_uwr", mem_write, 1);
    chk("rdy_udin", mem_din, 32'hDEADBEEF);
    user_write = 1'b0; scrub_en = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
